// File: rtl/button_event_detector.sv
// Push-button front end: synchronise, debounce, then report press, release,
// long-hold and auto-repeat events as single-cycle pulses.
module button_event_detector #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter int REPEAT_CYC   = 20_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_button,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic       o_repeat,
  output logic [2:0] dbg_state
);

  localparam int MAX_AB  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DEB_PRESS   = 3'd1,
    S_PRESSED     = 3'd2,
    S_HELD        = 3'd3,
    S_DEB_RELEASE = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          sync_meta;
  logic          sync;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] rep_cnt;
  logic          ret_held;
  logic          press_nxt;
  logic          release_nxt;
  logic          long_nxt;
  logic          repeat_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= i_button;
      sync      <= sync_meta;
    end
  end

  // State register plus the counters and registered event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      ret_held  <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
      o_long    <= long_nxt;
      o_repeat  <= repeat_nxt;

      if (state_nxt != state) begin
        deb_cnt <= '0;
      end else if (state == S_DEB_PRESS || state == S_DEB_RELEASE) begin
        deb_cnt <= deb_cnt + CNT_ONE;
      end

      if (state == S_IDLE || state == S_DEB_PRESS) begin
        hold_cnt <= '0;
      end else if (state == S_PRESSED && state_nxt != S_HELD) begin
        hold_cnt <= hold_cnt + CNT_ONE;
      end

      // The repeat counter keeps its value across a release bounce so the
      // cadence only slips by the cycles spent in DEB_RELEASE.
      if (state == S_HELD) begin
        rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + CNT_ONE;
      end else if (state != S_DEB_RELEASE) begin
        rep_cnt <= '0;
      end

      if (state_nxt == S_DEB_RELEASE && state != S_DEB_RELEASE) begin
        ret_held <= (state == S_HELD);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (sync) state_nxt = S_DEB_PRESS;
      end
      S_DEB_PRESS: begin
        if (!sync)                   state_nxt = S_IDLE;
        else if (deb_cnt == DEB_LAST) state_nxt = S_PRESSED;
      end
      S_PRESSED: begin
        // A long hold that completes on the same cycle as a low sample still
        // reports o_long; the release is then debounced from HELD.
        if (hold_cnt == LONG_LAST) state_nxt = S_HELD;
        else if (!sync)            state_nxt = S_DEB_RELEASE;
      end
      S_HELD: begin
        if (!sync) state_nxt = S_DEB_RELEASE;
      end
      S_DEB_RELEASE: begin
        if (sync)                     state_nxt = ret_held ? S_HELD : S_PRESSED;
        else if (deb_cnt == DEB_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    press_nxt   = (state == S_DEB_PRESS)   && (state_nxt == S_PRESSED);
    release_nxt = (state == S_DEB_RELEASE) && (state_nxt == S_IDLE);
    long_nxt    = (state == S_PRESSED)     && (state_nxt == S_HELD);
    repeat_nxt  = (state == S_HELD)        && (rep_cnt == REP_LAST);
    o_level     = (state == S_PRESSED) || (state == S_HELD) ||
                  (state == S_DEB_RELEASE);
    dbg_state   = state;
  end

endmodule

// File: tb/tb_button_event_detector.sv
// Directed bench for button_event_detector with short debounce/long/repeat
// periods; events are logged with their cycle stamp and compared in order.
module tb_button_event_detector;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 5;

  localparam logic [3:0] K_PRESS   = 4'd1;
  localparam logic [3:0] K_RELEASE = 4'd2;
  localparam logic [3:0] K_LONG    = 4'd3;
  localparam logic [3:0] K_REPEAT  = 4'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_button = 1'b0;
  logic       o_level;
  logic       o_press;
  logic       o_release;
  logic       o_long;
  logic       o_repeat;
  logic [2:0] dbg_state;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          mutex_viol = 0;
  int unsigned base;
  int unsigned p;
  int unsigned rbase;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  button_event_detector #(
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LNG),
    .REPEAT_CYC  (REP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_button (i_button),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_repeat (o_repeat),
    .dbg_state(dbg_state)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] evt(input logic [3:0] k, input int unsigned c);
    logic [31:0] cw;
    cw = c;
    return {k, cw[27:0]};
  endfunction

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (o_press)   obs_q.push_back(evt(K_PRESS, cyc));
    if (o_release) obs_q.push_back(evt(K_RELEASE, cyc));
    if (o_long)    obs_q.push_back(evt(K_LONG, cyc));
    if (o_repeat)  obs_q.push_back(evt(K_REPEAT, cyc));
    if ($countones({o_press, o_release, o_long, o_repeat}) > 1) mutex_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   {31'd0, o_level},   32'd0);
    check({tag, "_press"},   {31'd0, o_press},   32'd0);
    check({tag, "_release"}, {31'd0, o_release}, 32'd0);
    check({tag, "_long"},    {31'd0, o_long},    32'd0);
    check({tag, "_repeat"},  {31'd0, o_repeat},  32'd0);
    check({tag, "_state"},   {29'd0, dbg_state}, 32'd0);
  endtask

  task automatic sb_compare(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_evt"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    tick(3);
    reset = 1'b1;
    tick(3);
    obs_q.delete();

    // Clean press then short press release
    base = cyc + 1;
    i_button = 1'b1;
    exp_q.push_back(evt(K_PRESS, base + 6));
    tick(6);
    check("pre_press_level", {31'd0, o_level}, 32'd0);
    check("pre_press_pulse", {31'd0, o_press}, 32'd0);
    tick(1);
    check("press_pulse", {31'd0, o_press}, 32'd1);
    check("press_level", {31'd0, o_level}, 32'd1);
    tick(10);
    rbase = cyc + 1;
    i_button = 1'b0;
    exp_q.push_back(evt(K_RELEASE, rbase + 6));
    tick(10);
    check("short_level_after", {31'd0, o_level}, 32'd0);
    sb_compare("short");

    // Bounce on press
    base = cyc + 1;
    for (int i = 0; i < 7; i++) begin
      i_button = (i == 2) ? 1'b0 : 1'b1;
      tick(1);
    end
    exp_q.push_back(evt(K_PRESS, base + 9));
    tick(4);
    rbase = cyc + 1;
    i_button = 1'b0;
    exp_q.push_back(evt(K_RELEASE, rbase + 6));
    tick(10);
    sb_compare("bounce");

    // Long hold with repeats
    base = cyc + 1;
    p = base + 6;
    i_button = 1'b1;
    exp_q.push_back(evt(K_PRESS, p));
    exp_q.push_back(evt(K_LONG, p + 20));
    for (int k = 1; k <= 4; k++) exp_q.push_back(evt(K_REPEAT, p + 20 + 5 * k));
    tick(47);
    rbase = cyc + 1;
    i_button = 1'b0;
    exp_q.push_back(evt(K_RELEASE, rbase + 6));
    tick(10);
    sb_compare("long");

    // Release bounce while held shifts the repeat cadence by two
    base = cyc + 1;
    p = base + 6;
    i_button = 1'b1;
    exp_q.push_back(evt(K_PRESS, p));
    exp_q.push_back(evt(K_LONG, p + 20));
    exp_q.push_back(evt(K_REPEAT, p + 25));
    exp_q.push_back(evt(K_REPEAT, p + 30));
    tick(37);
    i_button = 1'b0;
    tick(2);
    i_button = 1'b1;
    tick(11);
    check("held_bounce_level", {31'd0, o_level}, 32'd1);
    exp_q.push_back(evt(K_REPEAT, p + 37));
    exp_q.push_back(evt(K_REPEAT, p + 42));
    rbase = cyc + 1;
    i_button = 1'b0;
    exp_q.push_back(evt(K_RELEASE, rbase + 6));
    tick(10);
    sb_compare("held_bounce");

    // Reset in HELD, button kept down through and after reset
    base = cyc + 1;
    p = base + 6;
    i_button = 1'b1;
    exp_q.push_back(evt(K_PRESS, p));
    exp_q.push_back(evt(K_LONG, p + 20));
    tick(29);
    check("pre_reset_level", {31'd0, o_level}, 32'd1);
    reset = 1'b0;
    #1 check_all_zero("mid_reset");
    tick(3);
    check("in_reset_level", {31'd0, o_level}, 32'd0);
    reset = 1'b1;
    base = cyc + 1;
    exp_q.push_back(evt(K_PRESS, base + 6));
    tick(16);
    check("post_reset_level", {31'd0, o_level}, 32'd1);
    sb_compare("reset_held");

    check("mutex", mutex_viol, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_detector.md
BUTTON_EVENT_DETECTOR -- requirements
Module: button_event_detector

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 1_000_000, meaning the stable-input cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter LONG_CYC, default 100_000_000, meaning the cycles from o_press to o_long (1 s).
REQ-003 The block SHALL have parameter REPEAT_CYC, default 20_000_000, meaning the cycles between o_repeat pulses while held (200 ms).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-006 The block SHALL have port i_button, input, 1 bit: raw, asynchronous, bouncing push-button, active-high.
REQ-007 The block SHALL have port o_level, output, 1 bit: the debounced button level.
REQ-008 The block SHALL have port o_press, output, 1 bit: one-cycle pulse on an accepted press; this is the pulse consumed by the stopwatch FSM run/stop and clear inputs.
REQ-009 The block SHALL have port o_release, output, 1 bit: one-cycle pulse on an accepted release.
REQ-010 The block SHALL have port o_long, output, 1 bit: one-cycle pulse when the button has been held LONG_CYC cycles.
REQ-011 The block SHALL have port o_repeat, output, 1 bit: one-cycle pulse every REPEAT_CYC cycles after o_long while held.

Function
REQ-012 The block SHALL pass i_button through a 2-flop synchronizer; only its output (sync) is used by the logic.
REQ-013 The block SHALL implement an FSM with states IDLE, DEB_PRESS, PRESSED, HELD and DEB_RELEASE.
REQ-014 The debounce counter SHALL clear on entry to DEB_PRESS/DEB_RELEASE and increment each cycle the sync level matches the target level.
REQ-015 IDLE SHALL go to DEB_PRESS when sync=1.
REQ-016 DEB_PRESS SHALL return to IDLE on sync=0 (bounce), emitting no pulse.
REQ-017 DEB_PRESS SHALL go to PRESSED once sync has been 1 for DEBOUNCE_CYC consecutive cycles.
REQ-018 The o_press pulse SHALL be registered, high for exactly the first cycle in PRESSED, so press latency is DEBOUNCE_CYC+2 cycles from the first edge sampling i_button=1.
REQ-019 In PRESSED, the hold counter SHALL count from 0 on entry.
REQ-020 PRESSED SHALL go to HELD with o_long pulsed for one cycle when the hold count reaches LONG_CYC.
REQ-021 In HELD, the repeat counter SHALL count from 0.
REQ-022 In HELD, o_repeat SHALL pulse and the repeat counter SHALL wrap to 0 every REPEAT_CYC cycles; the first o_repeat comes REPEAT_CYC cycles after o_long.
REQ-023 PRESSED or HELD SHALL go to DEB_RELEASE on sync=0, with the originating state remembered.
REQ-024 In DEB_RELEASE, the hold and repeat counters SHALL freeze.
REQ-025 DEB_RELEASE SHALL return to the remembered state on sync=1 (bounce), with counters resuming unchanged and no pulse emitted.
REQ-026 DEB_RELEASE SHALL go to IDLE with o_release pulsed for one cycle once sync has been 0 for DEBOUNCE_CYC consecutive cycles.
REQ-027 o_level SHALL be 1 in PRESSED, HELD and DEB_RELEASE, and 0 in IDLE and DEB_PRESS.
REQ-028 At most one of o_press, o_release, o_long and o_repeat SHALL be high in any cycle.
REQ-029 Counter widths SHALL be $clog2(max(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)+1) bits, and no counter SHALL ever wrap except the repeat counter.
REQ-030 Parameter legality SHALL be DEBOUNCE_CYC>=2, LONG_CYC>=2 and REPEAT_CYC>=2; other values are unsupported.
REQ-031 A release accepted before LONG_CYC SHALL produce o_press then o_release only, with no o_long.

Reset
REQ-032 While reset=0, the block SHALL immediately force the FSM to IDLE, clear both synchronizer flops, clear all counters, and drive all outputs to 0.
REQ-033 Reset asserted mid-press SHALL discard the press, and no o_release SHALL follow.
REQ-034 After reset deasserts, a button already held SHALL be treated as a new press: full debounce, then o_press.

Verification
REQ-035 Verification SHALL use DEBOUNCE_CYC=4, LONG_CYC=20 and REPEAT_CYC=5 for all scenarios below.
REQ-036 Clean press: i_button 0->1 held -> o_press single pulse exactly 6 cycles after the first sampled high, and o_level=1 in the same cycle.
REQ-037 Bounce: i_button pattern 1,1,0,1,1,1,1 -> no o_press until 4 stable highs after the last 0, and exactly one o_press pulse.
REQ-038 Short press: hold 10 cycles after o_press, then release clean -> o_release 6 cycles after the first sampled low, and no o_long.
REQ-039 Long hold: hold 40 cycles after o_press -> o_long at cycle 20, then o_repeat at cycles 25, 30, 35 and 40.
REQ-040 Release bounce in HELD: 2 lows then high -> return to HELD, no o_release, and the repeat cadence is shifted by exactly 2 cycles.
REQ-041 Reset mid-HELD: reset=0 for 3 cycles -> all outputs 0 within the same cycle, no o_release; with the button still held after deassertion -> o_press 6 cycles later.
